vga_char_pixel_pipeline: RTL and testbench

- Downstream consumer of the character-map dual-port BRAM: generates VGA timing and drives the BRAM read port (port B, 1-cycle registered read) with character-map addresses.
- Turns each returned character code into a font-RAM row address, then serialises the font row into a 1-bit pixel stream, with sync/blank aligned to the pixel.
- Runs on the pixel clock. Both RAMs are external, synchronous-read, with 1-cycle latency.

---
 rtl/vga_char_pixel_pipeline.sv | 154 +++++++++++++++
 tb/tb_vga_char_pixel_pipeline.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/vga_char_pixel_pipeline.sv
// VGA text-mode pixel pipeline: timing counters drive the char-map and font RAM reads,
// and a 5-deep tag pipeline keeps sync/blank aligned with the serialised glyph pixel.
module vga_char_pixel_pipeline #(
  parameter int H_ACTIVE           = 640,
  parameter int H_FP               = 16,
  parameter int H_SYNC             = 96,
  parameter int H_BP               = 48,
  parameter int V_ACTIVE           = 480,
  parameter int V_FP               = 10,
  parameter int V_SYNC             = 2,
  parameter int V_BP               = 33,
  parameter int CHAR_W             = 8,
  parameter int CHAR_H             = 16,
  parameter int CODE_WIDTH         = 8,
  parameter int CHARMAP_ADDR_WIDTH = 12,
  parameter int SYNC_ACTIVE_LOW    = 1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  output logic [CHARMAP_ADDR_WIDTH-1:0]         charmap_addr_o,
  input  logic [CODE_WIDTH-1:0]                 charmap_data_i,
  output logic [CODE_WIDTH+$clog2(CHAR_H)-1:0]  font_addr_o,
  input  logic [CHAR_W-1:0]                     font_data_i,
  output logic                                  hsync_o,
  output logic                                  vsync_o,
  output logic                                  de_o,
  output logic                                  pixel_o,
  output logic                                  frame_start_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int SXW     = (CHAR_W > 1) ? $clog2(CHAR_W) : 1;
  localparam int GRW     = $clog2(CHAR_H);
  localparam int AW      = CHARMAP_ADDR_WIDTH;
  localparam int COLS    = H_ACTIVE / CHAR_W;
  localparam int ROWS    = V_ACTIVE / CHAR_H;

  localparam logic [HW-1:0]  H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]  H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0]  H_ALST = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0]  H_SS   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0]  H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0]  V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]  V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0]  V_SS   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0]  V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [SXW-1:0] SX_LAST = SXW'(CHAR_W - 1);
  localparam logic [GRW-1:0] GR_LAST = GRW'(CHAR_H - 1);
  localparam logic [AW-1:0]  COLS_A  = AW'(COLS);
  localparam logic [AW-1:0]  RB_LAST = AW'((ROWS - 1) * COLS);
  localparam logic           SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);

  logic [HW-1:0]  h_cnt;
  logic [VW-1:0]  v_cnt;
  logic [SXW-1:0] sub_x;
  logic [AW-1:0]  col, row_base;
  logic [GRW-1:0] glyph_row;
  logic           active, hs, vs, fs, line_end, frame_end;

  logic [3:0]          t_de, t_hs, t_vs, t_fs;
  logic [3:0][SXW-1:0] t_sx;
  logic [1:0][GRW-1:0] t_gr;

  assign active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs        = (h_cnt >= H_SS) && (h_cnt < H_SE);
  assign vs        = (v_cnt >= V_SS) && (v_cnt < V_SE);
  assign fs        = (h_cnt == '0) && (v_cnt == '0);
  assign line_end  = (h_cnt == H_LAST);
  assign frame_end = line_end && (v_cnt == V_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (line_end) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  // Horizontal position is cleared on the way into h_cnt==0 so it reads 0 there.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sub_x <= '0;
      col   <= '0;
    end else if (line_end) begin
      sub_x <= '0;
      col   <= '0;
    end else if (active) begin
      if (sub_x == SX_LAST) begin
        sub_x <= '0;
        col   <= col + AW'(1);
      end else begin
        sub_x <= sub_x + SXW'(1);
      end
    end
  end

  // Wrapping row_base after the last text row keeps the address inside the map.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      glyph_row <= '0;
      row_base  <= '0;
    end else if (frame_end) begin
      glyph_row <= '0;
      row_base  <= '0;
    end else if (active && (h_cnt == H_ALST)) begin
      if (glyph_row == GR_LAST) begin
        glyph_row <= '0;
        row_base  <= (row_base == RB_LAST) ? '0 : row_base + COLS_A;
      end else begin
        glyph_row <= glyph_row + GRW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      charmap_addr_o <= '0;
      font_addr_o    <= '0;
      t_de <= '0;
      t_hs <= '0;
      t_vs <= '0;
      t_fs <= '0;
      t_sx <= '0;
      t_gr <= '0;
      pixel_o       <= 1'b0;
      de_o          <= 1'b0;
      frame_start_o <= 1'b0;
      hsync_o       <= SYNC_IDLE;
      vsync_o       <= SYNC_IDLE;
    end else begin
      if (active) charmap_addr_o <= row_base + col;
      t_de <= {t_de[2:0], active};
      t_hs <= {t_hs[2:0], hs};
      t_vs <= {t_vs[2:0], vs};
      t_fs <= {t_fs[2:0], fs};
      t_sx <= {t_sx[2:0], sub_x};
      t_gr <= {t_gr[0], glyph_row};
      font_addr_o   <= {charmap_data_i, t_gr[1]};
      pixel_o       <= t_de[3] & font_data_i[SX_LAST - t_sx[3]];
      de_o          <= t_de[3];
      frame_start_o <= t_fs[3];
      hsync_o       <= t_hs[3] ^ SYNC_IDLE;
      vsync_o       <= t_vs[3] ^ SYNC_IDLE;
    end
  end

endmodule

// File: tb/tb_vga_char_pixel_pipeline.sv
// Bench: a default-size instance for line-level timing and a reduced-size instance
// for whole-frame behaviour, both fed by registered char-map/font RAM models.
module tb_vga_char_pixel_pipeline;

  localparam int NREC = 14000;

  typedef struct {int n; int de; int hs; int vs; int fs; int px;} vec_t;
  typedef struct {int n; int sml; int addr;} avec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [11:0] ca_b, fa_b, ca_s, fa_s;
  logic [7:0]  cd_b, fd_b, cd_s, fd_s;
  logic hs_b, vs_b, de_b, px_b, fs_b;
  logic hs_s, vs_s, de_s, px_s, fs_s;

  vga_char_pixel_pipeline dut_b (
    .clk_i(clk), .rst_i(rst),
    .charmap_addr_o(ca_b), .charmap_data_i(cd_b),
    .font_addr_o(fa_b), .font_data_i(fd_b),
    .hsync_o(hs_b), .vsync_o(vs_b), .de_o(de_b), .pixel_o(px_b), .frame_start_o(fs_b)
  );

  vga_char_pixel_pipeline #(
    .H_ACTIVE(32), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(32), .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) dut_s (
    .clk_i(clk), .rst_i(rst),
    .charmap_addr_o(ca_s), .charmap_data_i(cd_s),
    .font_addr_o(fa_s), .font_data_i(fd_s),
    .hsync_o(hs_s), .vsync_o(vs_s), .de_o(de_s), .pixel_o(px_s), .frame_start_o(fs_s)
  );

  // Glyph 0x41: row 0 = 1000_0001, other rows = {row, ~row}; any other code is blank.
  function automatic logic [7:0] font_fn(input logic [11:0] a);
    logic [3:0] r;
    r = a[3:0];
    if (a[11:4] != 8'h41) return 8'h00;
    if (r == 4'd0) return 8'h81;
    return {r, ~r};
  endfunction

  always @(posedge clk) begin
    cd_b <= (ca_b < 12'd2400) ? 8'h41 : 8'h00;
    cd_s <= (ca_s < 12'd8) ? 8'h41 : 8'h00;
    fd_b <= font_fn(fa_b);
    fd_s <= font_fn(fa_s);
  end

  int ncmp = 0;
  int nfail = 0;
  int n = 0;
  logic [4:0]  hb [0:NREC];
  logic [4:0]  hsm[0:NREC];
  logic [11:0] cab[0:NREC];
  logic [11:0] cas[0:NREC];
  logic [11:0] fab[0:NREC];

  task automatic chk(input string name, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    n++;
    if (n <= NREC) begin
      hb[n]  = {de_b, hs_b, vs_b, fs_b, px_b};
      hsm[n] = {de_s, hs_s, vs_s, fs_s, px_s};
      cab[n] = ca_b;
      cas[n] = ca_s;
      fab[n] = fa_b;
    end
  endtask

  // n = clocks since reset release; pixel of counter state t shows at n = t+5.
  vec_t bt [23] = '{
    '{1,0,1,1,0,0},     '{4,0,1,1,0,0},     '{5,1,1,1,1,1},     '{6,1,1,1,0,0},
    '{12,1,1,1,0,1},    '{13,1,1,1,0,1},    '{14,1,1,1,0,0},    '{644,1,1,1,0,1},
    '{645,0,1,1,0,0},   '{660,0,1,1,0,0},   '{661,0,0,1,0,0},   '{756,0,0,1,0,0},
    '{757,0,1,1,0,0},   '{805,1,1,1,0,0},   '{808,1,1,1,0,1},   '{1606,1,1,1,0,0},
    '{1607,1,1,1,0,1},  '{12805,1,1,1,0,1}, '{13605,1,1,1,0,0}, '{13608,1,1,1,0,1},
    '{13611,1,1,1,0,1}, '{13612,1,1,1,0,0}, '{13900,1,1,1,0,0}
  };

  vec_t st [13] = '{
    '{5,1,1,1,1,1},    '{36,1,1,1,0,1},   '{37,0,1,1,0,0},   '{40,0,1,1,0,0},
    '{41,0,0,1,0,0},   '{48,0,0,1,0,0},   '{49,0,1,1,0,0},   '{1636,0,1,1,0,0},
    '{1637,0,1,0,0,0}, '{1732,0,1,0,0,0}, '{1733,0,1,1,0,0}, '{1829,1,1,1,1,1},
    '{1830,1,1,1,0,0}
  };

  avec_t at [15] = '{
    '{1,0,0},    '{8,0,0},     '{9,0,1},       '{640,0,79},  '{641,0,79},
    '{800,0,79}, '{801,0,0},   '{12801,0,80},  '{13440,0,159},
    '{1,1,0},    '{32,1,3},    '{769,1,4},     '{1520,1,7},  '{1824,1,7}, '{1825,1,0}
  };

  initial begin
    int cnt_de, cnt_hs, cnt_sde, cnt_svs;
    vec_t v;
    logic [4:0] s;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset de", de_b, 0);
    chk("reset pixel", px_b, 0);
    chk("reset hsync", hs_b, 1);
    chk("reset vsync", vs_b, 1);
    chk("reset frame_start", fs_b, 0);
    chk("reset charmap_addr", ca_b, 0);
    chk("reset font_addr", fa_b, 0);
    rst = 1'b0;
    n = 0;

    while (n < 13900) step();

    for (int i = 0; i < 23; i++) begin
      v = bt[i];
      s = hb[v.n];
      chk($sformatf("big n=%0d de", v.n), s[4], v.de);
      chk($sformatf("big n=%0d hsync", v.n), s[3], v.hs);
      chk($sformatf("big n=%0d vsync", v.n), s[2], v.vs);
      chk($sformatf("big n=%0d frame_start", v.n), s[1], v.fs);
      chk($sformatf("big n=%0d pixel", v.n), s[0], v.px);
    end
    for (int i = 0; i < 13; i++) begin
      v = st[i];
      s = hsm[v.n];
      chk($sformatf("small n=%0d de", v.n), s[4], v.de);
      chk($sformatf("small n=%0d hsync", v.n), s[3], v.hs);
      chk($sformatf("small n=%0d vsync", v.n), s[2], v.vs);
      chk($sformatf("small n=%0d frame_start", v.n), s[1], v.fs);
      chk($sformatf("small n=%0d pixel", v.n), s[0], v.px);
    end
    for (int i = 0; i < 15; i++) begin
      if (at[i].sml != 0)
        chk($sformatf("small n=%0d charmap_addr", at[i].n), cas[at[i].n], at[i].addr);
      else
        chk($sformatf("big n=%0d charmap_addr", at[i].n), cab[at[i].n], at[i].addr);
    end

    chk("font_addr line0", fab[3], 12'h410);
    chk("font_addr line17", fab[13603], 12'h411);

    cnt_de = 0; cnt_hs = 0; cnt_sde = 0; cnt_svs = 0;
    for (int k = 805; k < 1605; k++) begin
      s = hb[k];
      cnt_de += s[4];
      cnt_hs += (s[3] == 1'b0) ? 1 : 0;
    end
    for (int k = 5; k < 1829; k++) begin
      s = hsm[k];
      cnt_sde += s[4];
      cnt_svs += (s[2] == 1'b0) ? 1 : 0;
    end
    chk("big de clocks per line", cnt_de, 640);
    chk("big hsync low clocks per line", cnt_hs, 96);
    chk("small de clocks per frame", cnt_sde, 1024);
    chk("small vsync low clocks per frame", cnt_svs, 96);

    // Mid-line reset at h_cnt=300, v_cnt=17 while de_o is high.
    #1 rst = 1'b1;
    #1;
    chk("async reset de", de_b, 0);
    chk("async reset pixel", px_b, 0);
    chk("async reset hsync", hs_b, 1);
    chk("async reset vsync", vs_b, 1);
    chk("async reset charmap_addr", ca_b, 0);
    chk("async reset font_addr", fa_b, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("restart k=%0d de", k), de_b, (k >= 5) ? 1 : 0);
      chk($sformatf("restart k=%0d frame_start", k), fs_b, (k == 5) ? 1 : 0);
      chk($sformatf("restart k=%0d pixel", k), px_b, (k == 5) ? 1 : 0);
      chk($sformatf("restart k=%0d hsync", k), hs_b, 1);
      chk($sformatf("restart k=%0d vsync", k), vs_b, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
